// File: rtl/axi_pkg.sv
// Shared AXI definitions for the default slave: response codes, FSM state
// enums and a saturating counter helper.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Add a small increment to a 16-bit counter, sticking at all-ones.
  function automatic logic [15:0] sat_add16(input logic [15:0] base, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, base} + {15'd0, inc};
    if (sum[16]) begin
      sat_add16 = 16'hFFFF;
    end else begin
      sat_add16 = sum[15:0];
    end
  endfunction

endpackage

// File: rtl/axi_default_slave_if.sv
// AXI4 bus bundle seen by the default slave. The master modport is the
// interconnect side, the slave modport is the responder side.
interface axi_default_slave_if #(
  parameter int ID_W   = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);

  logic [ID_W-1:0]     AWID;
  logic [31:0]         AWADDR;
  logic [LEN_W-1:0]    AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;

  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;

  logic [ID_W-1:0]     BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;

  logic [ID_W-1:0]     ARID;
  logic [31:0]         ARADDR;
  logic [LEN_W-1:0]    ARLEN;
  logic [2:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic                ARVALID;
  logic                ARREADY;

  logic [ID_W-1:0]     RID;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

endinterface

// File: rtl/axi_default_slave.sv
// AXI4 default slave: terminates every unmapped access with DECERR.
// Writes drain W beats until WLAST then return one B; reads return ARLEN+1
// zero-data beats. One outstanding transaction per direction; read and write
// run independently. All READY/VALID outputs decode registered state only.
// Optional build macro AXI_DEFSLV_ERRLOG_EN adds err_addr/err_is_wr/err_cnt,
// logging the last accepted address (AW wins a same-cycle tie) and a
// saturating count of accepted requests.
module axi_default_slave
  import axi_pkg::*;
#(
  parameter int ID_W   = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  axi_default_slave_if.slave s_axi
`ifdef AXI_DEFSLV_ERRLOG_EN
  ,
  output logic [31:0]        err_addr,
  output logic               err_is_wr,
  output logic [15:0]        err_cnt
`endif
);

  wr_state_t        wr_state_q, wr_state_d;
  logic [ID_W-1:0]  wr_id_q, wr_id_d;

  rd_state_t        rd_state_q, rd_state_d;
  logic [ID_W-1:0]  rd_id_q, rd_id_d;
  logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;

  logic aw_hs_s;
  logic ar_hs_s;

  // Address handshakes: ready is simply "channel idle".
  assign aw_hs_s = s_axi.AWVALID && (wr_state_q == W_IDLE);
  assign ar_hs_s = s_axi.ARVALID && (rd_state_q == R_IDLE);

  // Payload and attribute fields that a DECERR responder never looks at.
  logic unused_fields_s;
  assign unused_fields_s = ^{s_axi.AWADDR, s_axi.AWLEN, s_axi.AWSIZE, s_axi.AWBURST,
                             s_axi.WDATA, s_axi.WSTRB, s_axi.ARADDR, s_axi.ARSIZE,
                             s_axi.ARBURST};

  // ---------------------------------------------------------------- write
  // Write FSM state and latched AWID.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      wr_id_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_id_q    <= wr_id_d;
    end
  end

  // Write next-state: accept AW, drain W until WLAST, hold B until BREADY.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_id_d    = wr_id_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs_s) begin
          wr_state_d = W_DATA;
          wr_id_d    = s_axi.AWID;
        end else begin
          wr_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (s_axi.WVALID && s_axi.WLAST) begin
          wr_state_d = W_RESP;
        end else begin
          wr_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (s_axi.BREADY) begin
          wr_state_d = W_IDLE;
        end else begin
          wr_state_d = W_RESP;
        end
      end
      default: begin
        wr_state_d = W_IDLE;
      end
    endcase
  end

  // Write channel outputs decoded from the registered state.
  always_comb begin
    s_axi.AWREADY = (wr_state_q == W_IDLE);
    s_axi.WREADY  = (wr_state_q == W_DATA);
    s_axi.BVALID  = (wr_state_q == W_RESP);
    s_axi.BID     = wr_id_q;
    if (wr_state_q == W_RESP) begin
      s_axi.BRESP = RESP_DECERR;
    end else begin
      s_axi.BRESP = RESP_OKAY;
    end
  end

  // ----------------------------------------------------------------- read
  // Read FSM state, latched ARID and remaining-beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      rd_id_q    <= '0;
      rd_cnt_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_id_q    <= rd_id_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  // Read next-state: counter stops at zero, so it never wraps.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_id_d    = rd_id_q;
    rd_cnt_d   = rd_cnt_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          rd_state_d = R_DATA;
          rd_id_d    = s_axi.ARID;
          rd_cnt_d   = s_axi.ARLEN;
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (s_axi.RREADY) begin
          if (rd_cnt_q == '0) begin
            rd_state_d = R_IDLE;
          end else begin
            rd_cnt_d = rd_cnt_q - LEN_W'(1);
          end
        end else begin
          rd_state_d = R_DATA;
        end
      end
      default: begin
        rd_state_d = R_IDLE;
      end
    endcase
  end

  // Read channel outputs decoded from the registered state.
  always_comb begin
    s_axi.ARREADY = (rd_state_q == R_IDLE);
    s_axi.RVALID  = (rd_state_q == R_DATA);
    s_axi.RID     = rd_id_q;
    s_axi.RDATA   = {DATA_W{1'b0}};
    if (rd_state_q == R_DATA) begin
      s_axi.RRESP = RESP_DECERR;
      s_axi.RLAST = (rd_cnt_q == '0);
    end else begin
      s_axi.RRESP = RESP_OKAY;
      s_axi.RLAST = 1'b0;
    end
  end

`ifdef AXI_DEFSLV_ERRLOG_EN
  // ------------------------------------------------------------ error log
  logic [31:0] err_addr_q, err_addr_d;
  logic        err_is_wr_q, err_is_wr_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Error log registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_addr_q  <= 32'd0;
      err_is_wr_q <= 1'b0;
      err_cnt_q   <= 16'd0;
    end else begin
      err_addr_q  <= err_addr_d;
      err_is_wr_q <= err_is_wr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Capture the accepted address (write wins a tie) and count both requests.
  always_comb begin
    err_addr_d  = err_addr_q;
    err_is_wr_d = err_is_wr_q;
    if (aw_hs_s) begin
      err_addr_d  = s_axi.AWADDR;
      err_is_wr_d = 1'b1;
    end else if (ar_hs_s) begin
      err_addr_d  = s_axi.ARADDR;
      err_is_wr_d = 1'b0;
    end else begin
      err_addr_d  = err_addr_q;
      err_is_wr_d = err_is_wr_q;
    end
    err_cnt_d = sat_add16(err_cnt_q, {1'b0, aw_hs_s} + {1'b0, ar_hs_s});
  end

  assign err_addr  = err_addr_q;
  assign err_is_wr = err_is_wr_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule
